instr_aligner: RTL

- Fetch-side producer of the instruction stream consumed by the decode stage, including the RVC decoder.
- Accepts 32-bit aligned fetch words and emits one whole instruction per cycle: either a 16-bit RVC instruction, zero-extended, or a 32-bit instruction.
- Handles 32-bit instructions straddling word boundaries and halfword-aligned redirect targets.
- Sits between the fetch buffer and the ID-stage decoders.

---
 rtl/instr_aligner_pkg.sv | 16 +
 rtl/aligner_hwbuf.sv | 60 ++++++
 rtl/instr_aligner.sv | 107 ++++++++++
 3 files changed

// File: rtl/instr_aligner_pkg.sv
// Shared types and helpers for the fetch-side instruction aligner.
package instr_aligner_pkg;

  localparam int unsigned HW_SIZE = 16;

  typedef struct packed {
    logic [HW_SIZE-1:0] data;
    logic               err;
  } hw_entry_t;

  // Compressed instructions are every encoding whose low two bits are not 2'b11.
  function automatic logic is_rvc(input logic [1:0] op);
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/aligner_hwbuf.sv
// Halfword shift buffer: pops 0/1/2 from the head, then appends 0/1/2 at the new tail.
module aligner_hwbuf
  import instr_aligner_pkg::*;
#(
  parameter int unsigned SLOTS = 3,
  localparam int unsigned CW   = $clog2(SLOTS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic [1:0]      pop_size_i,
  input  logic [1:0]      push_size_i,
  input  hw_entry_t       push_hw0_i,
  input  hw_entry_t       push_hw1_i,
  output logic [CW-1:0]   count_o,
  output hw_entry_t       head0_o,
  output hw_entry_t       head1_o
);

  hw_entry_t          mem_q [SLOTS];
  hw_entry_t          mem_d [SLOTS];
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      kept;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    kept    = count_q - CW'(pop_size_i);
    if (clear_i) begin
      count_d = '0;
    end else begin
      case (pop_size_i)
        2'd1: for (int i = 0; i < int'(SLOTS) - 1; i++) mem_d[i] = mem_q[i+1];
        2'd2: for (int i = 0; i < int'(SLOTS) - 2; i++) mem_d[i] = mem_q[i+2];
        default: ;
      endcase
      // Append lands right behind whatever survived the pop.
      for (int i = 0; i < int'(SLOTS); i++) begin
        if (CW'(i) == kept && push_size_i != 2'd0) mem_d[i] = push_hw0_i;
        if (CW'(i) == kept + CW'(1) && push_size_i == 2'd2) mem_d[i] = push_hw1_i;
      end
      count_d = kept + CW'(push_size_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < int'(SLOTS); i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign count_o = count_q;
  assign head0_o = mem_q[0];
  assign head1_o = mem_q[1];

endmodule

// File: rtl/instr_aligner.sv
// Turns aligned 32-bit fetch words into one whole RVC or 32-bit instruction per cycle.
module instr_aligner
  import instr_aligner_pkg::*;
#(
  parameter int unsigned HW_SLOTS = 3
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_flush_i,
  input  logic [31:0] s_fpc_i,
  input  logic        s_fvalid_i,
  input  logic [31:0] s_fdata_i,
  input  logic        s_ferr_i,
  output logic        s_fready_o,
  output logic        s_valid_o,
  input  logic        s_ready_i,
  output logic [31:0] s_instr_o,
  output logic        s_rvc_o,
  output logic [31:0] s_pc_o,
  output logic        s_err_o
);

  localparam int unsigned CW = $clog2(HW_SLOTS + 1);

  logic [CW-1:0] count;
  hw_entry_t     head0, head1;
  hw_entry_t     push_hw0, push_hw1;
  logic [1:0]    pop_size, push_size;
  logic [31:0]   pc_q, pc_d;
  logic          skip_q, skip_d;
  logic          size1, head_ok, pop, push;
  logic [31:0]   instr_raw;
  logic          err_raw;
  logic          unused_fpc0;

  assign unused_fpc0 = s_fpc_i[0];

  // Head classification: an errored head is always emitted alone as a 16-bit slot.
  always_comb begin
    size1     = head0.err | is_rvc(head0.data[1:0]);
    head_ok   = size1 ? (count != '0) : (count >= CW'(2));
    instr_raw = '0;
    err_raw   = 1'b0;
    if (head0.err) begin
      err_raw = 1'b1;
    end else if (size1) begin
      instr_raw = {16'h0000, head0.data};
    end else begin
      instr_raw = {head1.data, head0.data};
      err_raw   = head1.err;
    end
  end

  always_comb begin
    s_valid_o  = ~s_reset_i & ~s_flush_i & head_ok;
    pop        = s_valid_o & s_ready_i;
    pop_size   = pop ? (size1 ? 2'd1 : 2'd2) : 2'd0;
    s_fready_o = ~s_reset_i & ~s_flush_i &
                 (int'(count) - int'(pop_size) + 2 <= int'(HW_SLOTS));
    push       = s_fvalid_i & s_fready_o;
    push_size  = push ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
    push_hw0   = skip_q ? hw_entry_t'{s_fdata_i[31:16], s_ferr_i}
                        : hw_entry_t'{s_fdata_i[15:0], s_ferr_i};
    push_hw1   = hw_entry_t'{s_fdata_i[31:16], s_ferr_i};
  end

  always_comb begin
    pc_d   = pc_q;
    skip_d = skip_q;
    if (s_flush_i) begin
      pc_d   = {s_fpc_i[31:1], 1'b0};
      skip_d = s_fpc_i[1];
    end else begin
      if (pop)  pc_d   = pc_q + (size1 ? 32'd2 : 32'd4);
      if (push) skip_d = 1'b0;
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      pc_q   <= '0;
      skip_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      skip_q <= skip_d;
    end
  end

  aligner_hwbuf #(.SLOTS(HW_SLOTS)) u_hwbuf (
    .clk         (s_clk_i),
    .rst         (s_reset_i),
    .clear_i     (s_flush_i),
    .pop_size_i  (pop_size),
    .push_size_i (push_size),
    .push_hw0_i  (push_hw0),
    .push_hw1_i  (push_hw1),
    .count_o     (count),
    .head0_o     (head0),
    .head1_o     (head1)
  );

  assign s_instr_o = (head_ok & ~s_reset_i) ? instr_raw : '0;
  assign s_err_o   = head_ok & ~s_reset_i & err_raw;
  assign s_rvc_o   = head_ok & ~s_reset_i & size1;
  assign s_pc_o    = pc_q;

endmodule
